// File: rtl/alu_sweep_checker.sv
// Exhaustive stimulus/response checker for a 4-bit ALU: sweeps all {opcode, A, B} vectors and grades the responses.
// Optional macro ZERO_FLAG_CHECK_EN also compares the ALU zero flag against the golden model.
module alu_sweep_checker #(
  parameter int SETTLE_CYCLES = 0,
  parameter int CNT_W         = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [3:0]       dut_a,
  output logic [3:0]       dut_b,
  output logic [2:0]       dut_opcode,
  input  logic [3:0]       dut_result,
  input  logic             dut_zero,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [7:0]       fail_mask,
  output logic             first_fail_valid,
  output logic [10:0]      first_fail_vec,
  output logic [3:0]       first_fail_result,
  output logic [1:0]       state_dbg
);

  // Handshake: start is a single-cycle request, accepted only when busy is low
  // (IDLE or DONE); done stays high until the next accepted start or rst.

  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  logic           loading;
  logic [10:0]    idx;
  logic [SW-1:0]  settle_cnt;
  logic [3:0]     gold_res;
  logic           gold_zero;
  logic           vec_fail;
  logic           last_hold;

  assign state_dbg = state;
  assign last_hold = (settle_cnt == SW'(SETTLE_CYCLES));

  always_comb begin
    gold_res = 4'h0;
    case (dut_opcode)
      3'd0: gold_res = dut_a + dut_b;
      3'd1: gold_res = dut_a - dut_b;
      3'd2: gold_res = dut_a & dut_b;
      3'd3: gold_res = dut_a | dut_b;
      3'd4: gold_res = dut_a ^ dut_b;
      3'd5: gold_res = {3'b000, (dut_a == dut_b)};
      3'd6: gold_res = {3'b000, (dut_a < dut_b)};
      default: gold_res = 4'h0;
    endcase
    gold_zero = (gold_res == 4'h0);
  end

`ifdef ZERO_FLAG_CHECK_EN
  // Result and zero-flag mismatches on the same vector count as one failure.
  assign vec_fail = (dut_result != gold_res) || (dut_zero != gold_zero);
`else
  logic unused_zero;
  assign unused_zero = dut_zero ^ gold_zero;
  assign vec_fail    = (dut_result != gold_res);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      loading           <= 1'b0;
      idx               <= 11'd0;
      settle_cnt        <= '0;
      dut_a             <= 4'h0;
      dut_b             <= 4'h0;
      dut_opcode        <= 3'h0;
      busy              <= 1'b0;
      done              <= 1'b0;
      mismatch_count    <= '0;
      fail_mask         <= 8'h00;
      first_fail_valid  <= 1'b0;
      first_fail_vec    <= 11'h000;
      first_fail_result <= 4'h0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state             <= SWEEP;
            loading           <= 1'b1;
            idx               <= 11'd0;
            settle_cnt        <= '0;
            busy              <= 1'b1;
            done              <= 1'b0;
            mismatch_count    <= '0;
            fail_mask         <= 8'h00;
            first_fail_valid  <= 1'b0;
            first_fail_vec    <= 11'h000;
            first_fail_result <= 4'h0;
          end
        end
        SWEEP: begin
          if (loading) begin
            // One cycle to move vector 0 from the index onto the ALU inputs.
            {dut_opcode, dut_a, dut_b} <= idx;
            loading    <= 1'b0;
            settle_cnt <= '0;
          end else if (!last_hold) begin
            settle_cnt <= settle_cnt + SW'(1);
          end else begin
            if (vec_fail) begin
              if (mismatch_count != {CNT_W{1'b1}})
                mismatch_count <= mismatch_count + CNT_W'(1);
              fail_mask[dut_opcode] <= 1'b1;
              if (!first_fail_valid) begin
                first_fail_valid  <= 1'b1;
                first_fail_vec    <= {dut_opcode, dut_a, dut_b};
                first_fail_result <= dut_result;
              end
            end
            if (idx == 11'h7FF) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx                        <= idx + 11'd1;
              {dut_opcode, dut_a, dut_b} <= idx + 11'd1;
              settle_cnt                 <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sweep_checker.sv
// Bench for alu_sweep_checker: table of ALU mutants per sweep, plus reset/restart/latency sequences.
module tb_alu_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start0 = 1'b0;
  logic        start2 = 1'b0;
  int          mode = 0;

  // Instance with SETTLE_CYCLES=0 and a bench ALU selectable by mode
  logic [3:0]  a0, b0, res0;
  logic [2:0]  op0;
  logic        zero0, busy0, done0, ffv0;
  logic [11:0] cnt0;
  logic [7:0]  mask0;
  logic [10:0] ffvec0;
  logic [3:0]  ffres0;
  logic [1:0]  st0;

  // Instance with SETTLE_CYCLES=2 and a 2-cycle registered golden ALU
  logic [3:0]  a2, b2, res2;
  logic [2:0]  op2;
  logic        zero2, busy2, done2, ffv2;
  logic [11:0] cnt2;
  logic [7:0]  mask2;
  logic [10:0] ffvec2;
  logic [3:0]  ffres2;
  logic [1:0]  st2;

  alu_sweep_checker #(.SETTLE_CYCLES(0), .CNT_W(12)) dut (
    .clk(clk), .rst(rst), .start(start0),
    .dut_a(a0), .dut_b(b0), .dut_opcode(op0),
    .dut_result(res0), .dut_zero(zero0),
    .busy(busy0), .done(done0), .mismatch_count(cnt0), .fail_mask(mask0),
    .first_fail_valid(ffv0), .first_fail_vec(ffvec0), .first_fail_result(ffres0),
    .state_dbg(st0)
  );

  alu_sweep_checker #(.SETTLE_CYCLES(2), .CNT_W(12)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .dut_a(a2), .dut_b(b2), .dut_opcode(op2),
    .dut_result(res2), .dut_zero(zero2),
    .busy(busy2), .done(done2), .mismatch_count(cnt2), .fail_mask(mask2),
    .first_fail_valid(ffv2), .first_fail_vec(ffvec2), .first_fail_result(ffres2),
    .state_dbg(st2)
  );

  function automatic logic [4:0] ref_alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (a == b) ? 4'd1 : 4'd0;
      3'd6: r = (a < b) ? 4'd1 : 4'd0;
      default: r = 4'd0;
    endcase
    return {(r == 4'd0), r};
  endfunction

  // Two-stage registered golden ALUs (bench-side models of a pipelined DUT)
  logic [4:0] p0_s1 = 5'h10, p0_s2 = 5'h10;
  logic [4:0] p2_s1 = 5'h10, p2_s2 = 5'h10;
  always @(posedge clk) begin
    p0_s1 <= ref_alu(op0, a0, b0);
    p0_s2 <= p0_s1;
    p2_s1 <= ref_alu(op2, a2, b2);
    p2_s2 <= p2_s1;
  end
  assign {zero2, res2} = p2_s2;

  // Mutant selection: 0 golden, 1 ADD/SUB MSB flipped, 2 NOP zero flipped,
  // 3 two-cycle latency, 4 LT result stuck at 0
  always_comb begin
    logic [4:0] g;
    g = ref_alu(op0, a0, b0);
    res0  = g[3:0];
    zero0 = g[4];
    case (mode)
      1: if (op0 == 3'd0 || op0 == 3'd1) res0 = g[3:0] ^ 4'h8;
      2: if (op0 == 3'd7) zero0 = ~g[4];
      3: begin res0 = p0_s2[3:0]; zero0 = p0_s2[4]; end
      4: if (op0 == 3'd6) res0 = 4'h0;
      default: ;
    endcase
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
  endtask

  // Starts a sweep on instance `which` (0 or 2) and counts edges until done.
  task automatic run_sweep(input int which, input int mid, output int cycles);
    @(negedge clk);
    if (which == 0) start0 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start2 = 1'b0;
    if (which == 0) begin
      check("start_busy", {31'd0, busy0}, 1);
      check("start_done_clear", {31'd0, done0}, 0);
      check("start_cnt_clear", {20'd0, cnt0}, 0);
      check("start_mask_clear", {24'd0, mask0}, 0);
      check("start_ffv_clear", {31'd0, ffv0}, 0);
    end else begin
      check("start2_busy", {31'd0, busy2}, 1);
    end
    cycles = 0;
    while (cycles < 20000) begin
      @(posedge clk); cycles++; #1;
      if ((which == 0) ? done0 : done2) break;
      start0 = (which == 0 && cycles == mid);
    end
    start0 = 1'b0;
    if (cycles >= 20000) check("sweep_timeout", 1, 0);
  endtask

  typedef struct {
    int          mode;
    int          exp_cnt;
    logic [7:0]  exp_mask;
    logic        exp_ffv;
    logic [10:0] exp_vec;
    logic [3:0]  exp_res;
  } vec_t;

  vec_t tbl[4];
  int   cyc;

  initial begin
    tbl[0] = '{mode: 0, exp_cnt: 0,   exp_mask: 8'h00, exp_ffv: 1'b0, exp_vec: 11'h000, exp_res: 4'h0};
    tbl[1] = '{mode: 1, exp_cnt: 512, exp_mask: 8'h03, exp_ffv: 1'b1, exp_vec: 11'h000, exp_res: 4'h8};
`ifdef ZERO_FLAG_CHECK_EN
    tbl[2] = '{mode: 2, exp_cnt: 256, exp_mask: 8'h80, exp_ffv: 1'b1, exp_vec: 11'h700, exp_res: 4'h0};
`else
    tbl[2] = '{mode: 2, exp_cnt: 0,   exp_mask: 8'h00, exp_ffv: 1'b0, exp_vec: 11'h000, exp_res: 4'h0};
`endif
    tbl[3] = '{mode: 4, exp_cnt: 120, exp_mask: 8'h40, exp_ffv: 1'b1, exp_vec: 11'h601, exp_res: 4'h0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {30'd0, st0}, 0);
    check("rst_vec", {21'd0, op0, a0, b0}, 0);
    check("rst_busy_done", {30'd0, busy0, done0}, 0);
    check("rst_cnt", {20'd0, cnt0}, 0);
    check("rst_ffv", {31'd0, ffv0}, 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      do_reset();
      mode = tbl[i].mode;
      run_sweep(0, 0, cyc);
      check($sformatf("t%0d_len", i), cyc, 2049);
      check($sformatf("t%0d_cnt", i), {20'd0, cnt0}, tbl[i].exp_cnt);
      check($sformatf("t%0d_mask", i), {24'd0, mask0}, {24'd0, tbl[i].exp_mask});
      check($sformatf("t%0d_ffv", i), {31'd0, ffv0}, {31'd0, tbl[i].exp_ffv});
      check($sformatf("t%0d_ffvec", i), {21'd0, ffvec0}, {21'd0, tbl[i].exp_vec});
      check($sformatf("t%0d_ffres", i), {28'd0, ffres0}, {28'd0, tbl[i].exp_res});
      check($sformatf("t%0d_done_state", i), {30'd0, st0}, 2);
      check($sformatf("t%0d_busy", i), {31'd0, busy0}, 0);
      check($sformatf("t%0d_last_vec", i), {21'd0, op0, a0, b0}, 32'h7FF);
    end

    // Start in DONE (after the LT mutant) clears results and reruns cleanly
    mode = 0;
    run_sweep(0, 0, cyc);
    check("restart_len", cyc, 2049);
    check("restart_cnt", {20'd0, cnt0}, 0);
    check("restart_ffv", {31'd0, ffv0}, 0);

    // Start mid-sweep is ignored
    run_sweep(0, 500, cyc);
    check("midstart_len", cyc, 2049);
    check("midstart_cnt", {20'd0, cnt0}, 0);

    // Reset mid-sweep with a failing mutant so results are non-zero first
    mode = 1;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("mid_busy", {31'd0, busy0}, 1);
    check("mid_cnt_nonzero", {31'd0, (cnt0 != 12'd0)}, 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_state", {30'd0, st0}, 0);
    check("midrst_vec", {21'd0, op0, a0, b0}, 0);
    check("midrst_flags", {30'd0, busy0, done0}, 0);
    check("midrst_cnt", {20'd0, cnt0}, 0);
    check("midrst_mask", {24'd0, mask0}, 0);
    check("midrst_ff", {16'd0, ffv0, ffvec0, ffres0}, 0);
    @(negedge clk); rst = 1'b0;
    mode = 0;
    run_sweep(0, 0, cyc);
    check("post_rst_len", cyc, 2049);
    check("post_rst_cnt", {20'd0, cnt0}, 0);

    // Two-cycle latency ALU on SETTLE_CYCLES=0 is flagged
    do_reset();
    mode = 3;
    run_sweep(0, 0, cyc);
    check("lat0_len", cyc, 2049);
    check("lat0_cnt_nonzero", {31'd0, (cnt0 != 12'd0)}, 1);
    check("lat0_ffvec", {21'd0, ffvec0}, 32'h001);
    check("lat0_ffres", {28'd0, ffres0}, 0);

    // Same latency covered by SETTLE_CYCLES=2
    do_reset();
    run_sweep(2, 0, cyc);
    check("settle2_len", cyc, 6145);
    check("settle2_cnt", {20'd0, cnt2}, 0);
    check("settle2_ffv", {31'd0, ffv2}, 0);
    check("settle2_state", {30'd0, st2}, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
